// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions.
// Access-size encodings and memory-stage FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT_RSP
  } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and load-data extraction.
// Undefined sizes fall through to word behaviour.
module load_store_align #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misalign
);
  import riscv_pkg::*;

  logic        is_b;
  logic        is_h;
  logic        sext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_b = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_h = (funct3 == F3_H) || (funct3 == F3_HU);
  assign sext = ~funct3[2];

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16]
                               : rdata[15:0];

  // Lane enables, replicated store data, extended load data
  always_comb begin
    be        = 4'b1111;
    wdata     = rs2_data;
    load_data = rdata;
    misalign  = 1'b0;
    unique case (1'b1)
      is_b: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{rs2_data[7:0]}};
        load_data = {{(XLEN-8){sext & byte_sel[7]}},
                     byte_sel};
      end
      is_h: begin
        be        = 4'b0011 << addr_lo;
        wdata     = {2{rs2_data[15:0]}};
        load_data = {{(XLEN-16){sext & half_sel[15]}},
                     half_sel};
        misalign  = addr_lo[0];
      end
      default: begin
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register.
// Drives a valid/ready data port and stalls the front end.
module mem_wb_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_MEM_valid,
  input  logic [4:0]        EX_MEM_Rd,
  input  logic              EX_MEM_RegWrite,
  input  logic              EX_MEM_MemRead,
  input  logic              EX_MEM_MemWrite,
  input  logic              EX_MEM_MemtoReg,
  input  logic [2:0]        EX_MEM_funct3,
  input  logic [XLEN-1:0]   EX_MEM_ALU_result,
  input  logic [XLEN-1:0]   EX_MEM_rs2_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              mem_stall,
  output logic              MEM_WB_valid,
  output logic [4:0]        MEM_WB_Rd,
  output logic              MEM_WB_RegWrite,
  output logic [XLEN-1:0]   MEM_WB_wdata,
  output logic              MEM_WB_misalign
);
  import riscv_pkg::*;

  mem_state_e      state_q, state_d;
  logic [1:0]      lo_q, lo_d;
  logic [2:0]      f3_q, f3_d;
  logic            in_wait;
  logic [2:0]      al_f3;
  logic [1:0]      al_lo;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ldata;
  logic            al_mis;
  logic            is_mem;
  logic            mis;
  logic            access;
  logic            req;
  logic            complete;

  logic            wb_valid_q;
  logic [4:0]      wb_rd_q;
  logic            wb_rw_q;
  logic [XLEN-1:0] wb_wdata_q;
  logic            wb_mis_q;

  assign in_wait = (state_q == MEM_WAIT_RSP);
  assign al_f3   = in_wait ? f3_q
                           : EX_MEM_funct3;
  assign al_lo   = in_wait ? lo_q
                           : EX_MEM_ALU_result[1:0];

  load_store_align #(.XLEN(XLEN)) u_align (
    .funct3    (al_f3),
    .addr_lo   (al_lo),
    .rs2_data  (EX_MEM_rs2_data),
    .rdata     (dmem_rdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (al_ldata),
    .misalign  (al_mis)
  );

  assign is_mem = EX_MEM_valid
                & (EX_MEM_MemRead | EX_MEM_MemWrite);
  assign mis    = is_mem & al_mis;
  assign access = is_mem & ~al_mis;

  assign dmem_req   = rst & req;
  assign dmem_we    = EX_MEM_MemWrite;
  assign dmem_addr  = {EX_MEM_ALU_result[ADDR_W-1:2],
                       2'b00};
  assign dmem_wdata = al_wdata;
  assign dmem_be    = EX_MEM_MemWrite ? al_be
                                      : 4'b1111;
  assign mem_stall  = rst & access & ~complete;

  // Request/response sequencing and load context capture
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    f3_d     = f3_q;
    req      = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        req = access;
        if (access && dmem_ready) begin
          if (EX_MEM_MemWrite) begin
            complete = 1'b1;
          end else begin
            state_d = MEM_WAIT_RSP;
            lo_d    = EX_MEM_ALU_result[1:0];
            f3_d    = EX_MEM_funct3;
          end
        end
      end
      MEM_WAIT_RSP: begin
        if (dmem_rvalid) begin
          complete = 1'b1;
          state_d  = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // FSM state and captured load context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MEM_IDLE;
      lo_q    <= 2'b00;
      f3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      f3_q    <= f3_d;
    end
  end

  // MEM/WB register: bubble while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_rw_q    <= 1'b0;
      wb_wdata_q <= '0;
      wb_mis_q   <= 1'b0;
    end else if (mem_stall) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_rw_q    <= 1'b0;
      wb_wdata_q <= '0;
      wb_mis_q   <= 1'b0;
    end else begin
      wb_valid_q <= EX_MEM_valid;
      wb_rd_q    <= EX_MEM_Rd;
      wb_rw_q    <= EX_MEM_RegWrite
                  & EX_MEM_valid & ~mis;
      wb_wdata_q <= EX_MEM_MemtoReg ? al_ldata
                                    : EX_MEM_ALU_result;
      wb_mis_q   <= mis;
    end
  end

  assign MEM_WB_valid    = wb_valid_q;
  assign MEM_WB_Rd       = wb_rd_q;
  assign MEM_WB_RegWrite = wb_rw_q;
  assign MEM_WB_wdata    = wb_wdata_q;
  assign MEM_WB_misalign = wb_mis_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
// Hand-computed expectations, immediate assertions.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_rw;
  logic        ex_mr;
  logic        ex_mw;
  logic        ex_m2r;
  logic [2:0]  ex_f3;
  logic [31:0] ex_alu;
  logic [31:0] ex_rs2;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_rw;
  logic [31:0] wb_wdata;
  logic        wb_mis;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk               (clk),
    .rst               (rst),
    .EX_MEM_valid      (ex_valid),
    .EX_MEM_Rd         (ex_rd),
    .EX_MEM_RegWrite   (ex_rw),
    .EX_MEM_MemRead    (ex_mr),
    .EX_MEM_MemWrite   (ex_mw),
    .EX_MEM_MemtoReg   (ex_m2r),
    .EX_MEM_funct3     (ex_f3),
    .EX_MEM_ALU_result (ex_alu),
    .EX_MEM_rs2_data   (ex_rs2),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_ready        (dmem_ready),
    .dmem_rvalid       (dmem_rvalid),
    .dmem_rdata        (dmem_rdata),
    .mem_stall         (mem_stall),
    .MEM_WB_valid      (wb_valid),
    .MEM_WB_Rd         (wb_rd),
    .MEM_WB_RegWrite   (wb_rw),
    .MEM_WB_wdata      (wb_wdata),
    .MEM_WB_misalign   (wb_mis)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h",
                tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic op(input logic v,
                    input logic [4:0] rd,
                    input logic rw, mr, mw, m2r,
                    input logic [2:0] f3,
                    input logic [31:0] alu, rs2);
    ex_valid = v;
    ex_rd    = rd;
    ex_rw    = rw;
    ex_mr    = mr;
    ex_mw    = mw;
    ex_m2r   = m2r;
    ex_f3    = f3;
    ex_alu   = alu;
    ex_rs2   = rs2;
  endtask

  task automatic bubble();
    op(0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
  endtask

  initial begin
    rst         = 1'b0;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    bubble();
    nxt();
    nxt();
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_rw",    {31'd0, wb_rw},    32'd0);
    chk("rst_wdata", wb_wdata,          32'd0);
    chk("rst_req",   {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    rst = 1'b1;
    nxt();

    // reset while waiting on a load response
    op(1, 3, 1, 1, 0, 1, 3'b010, 32'h100, 0);
    dmem_ready = 1'b1;
    #1;
    chk("rr_req0",   {31'd0, dmem_req},  32'd1);
    chk("rr_stall0", {31'd0, mem_stall}, 32'd1);
    nxt();
    chk("rr_req1",   {31'd0, dmem_req},  32'd0);
    chk("rr_stall1", {31'd0, mem_stall}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rr_stall2", {31'd0, mem_stall}, 32'd0);
    bubble();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    nxt();
    rst = 1'b1;
    nxt();
    chk("rr_valid", {31'd0, wb_valid}, 32'd0);
    chk("rr_rw",    {31'd0, wb_rw},    32'd0);
    chk("rr_wdata", wb_wdata,          32'd0);
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;

    // ALU instruction
    op(1, 5, 1, 0, 0, 0, 3'b000, 32'h1234, 0);
    #1;
    chk("alu_stall", {31'd0, mem_stall}, 32'd0);
    chk("alu_req",   {31'd0, dmem_req},  32'd0);
    nxt();
    chk("alu_valid", {31'd0, wb_valid}, 32'd1);
    chk("alu_rd",    {27'd0, wb_rd},    32'd5);
    chk("alu_rw",    {31'd0, wb_rw},    32'd1);
    chk("alu_wdata", wb_wdata,          32'h1234);
    bubble();

    // LB at 0x103, response after three stalled cycles
    op(1, 7, 1, 1, 0, 1, 3'b000, 32'h103, 0);
    #1;
    chk("lb_req",   {31'd0, dmem_req},  32'd1);
    chk("lb_addr",  dmem_addr,          32'h100);
    chk("lb_be",    {28'd0, dmem_be},   32'hF);
    chk("lb_st0",   {31'd0, mem_stall}, 32'd1);
    nxt();
    chk("lb_bub1",  {31'd0, wb_valid},  32'd0);
    chk("lb_req1",  {31'd0, dmem_req},  32'd0);
    chk("lb_st1",   {31'd0, mem_stall}, 32'd1);
    nxt();
    chk("lb_bub2",  {31'd0, wb_valid},  32'd0);
    chk("lb_st2",   {31'd0, mem_stall}, 32'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80FFFFFF;
    #1;
    chk("lb_st3",   {31'd0, mem_stall}, 32'd0);
    nxt();
    chk("lb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lb_rd",    {27'd0, wb_rd},    32'd7);
    chk("lb_rw",    {31'd0, wb_rw},    32'd1);
    chk("lb_wdata", wb_wdata,          32'hFFFFFF80);
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    bubble();

    // SH at 0x202 with ready low for two cycles
    op(1, 0, 0, 0, 1, 0, 3'b001, 32'h202, 32'hABCD1234);
    dmem_ready = 1'b0;
    #1;
    chk("sh_req0",  {31'd0, dmem_req},  32'd1);
    chk("sh_we",    {31'd0, dmem_we},   32'd1);
    chk("sh_be0",   {28'd0, dmem_be},   32'hC);
    chk("sh_wd0",   dmem_wdata,         32'h12341234);
    chk("sh_addr0", dmem_addr,          32'h200);
    chk("sh_st0",   {31'd0, mem_stall}, 32'd1);
    nxt();
    chk("sh_bub",   {31'd0, wb_valid},  32'd0);
    chk("sh_req1",  {31'd0, dmem_req},  32'd1);
    chk("sh_be1",   {28'd0, dmem_be},   32'hC);
    chk("sh_st1",   {31'd0, mem_stall}, 32'd1);
    nxt();
    dmem_ready = 1'b1;
    #1;
    chk("sh_req2",  {31'd0, dmem_req},  32'd1);
    chk("sh_wd2",   dmem_wdata,         32'h12341234);
    chk("sh_st2",   {31'd0, mem_stall}, 32'd0);
    nxt();
    chk("sh_valid", {31'd0, wb_valid}, 32'd1);
    chk("sh_rw",    {31'd0, wb_rw},    32'd0);
    chk("sh_mis",   {31'd0, wb_mis},   32'd0);
    bubble();

    // SB at 0x301 accepted immediately
    op(1, 0, 0, 0, 1, 0, 3'b000, 32'h301, 32'h0000005A);
    #1;
    chk("sb_be",    {28'd0, dmem_be},   32'h2);
    chk("sb_wd",    dmem_wdata,         32'h5A5A5A5A);
    chk("sb_st",    {31'd0, mem_stall}, 32'd0);
    nxt();
    chk("sb_valid", {31'd0, wb_valid}, 32'd1);

    // misaligned LW at 0x101
    op(1, 9, 1, 1, 0, 1, 3'b010, 32'h101, 0);
    #1;
    chk("mis_req",   {31'd0, dmem_req},  32'd0);
    chk("mis_stall", {31'd0, mem_stall}, 32'd0);
    nxt();
    chk("mis_valid", {31'd0, wb_valid}, 32'd1);
    chk("mis_flag",  {31'd0, wb_mis},   32'd1);
    chk("mis_rw",    {31'd0, wb_rw},    32'd0);
    chk("mis_rd",    {27'd0, wb_rd},    32'd9);

    // LHU at 0x002 followed by an ALU op
    op(1, 10, 1, 1, 0, 1, 3'b101, 32'h002, 0);
    #1;
    chk("lhu_req", {31'd0, dmem_req}, 32'd1);
    nxt();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h8001FFFF;
    #1;
    chk("lhu_st",  {31'd0, mem_stall}, 32'd0);
    nxt();
    chk("lhu_wd",  wb_wdata,          32'h00008001);
    chk("lhu_rw",  {31'd0, wb_rw},    32'd1);
    chk("lhu_rd",  {27'd0, wb_rd},    32'd10);
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    op(1, 11, 1, 0, 0, 0, 3'b000, 32'h55, 0);
    #1;
    chk("b2b_st",  {31'd0, mem_stall}, 32'd0);
    nxt();
    chk("b2b_rd",  {27'd0, wb_rd},    32'd11);
    chk("b2b_wd",  wb_wdata,          32'h55);
    chk("b2b_rw",  {31'd0, wb_rw},    32'd1);
    bubble();
    nxt();
    chk("end_bub", {31'd0, wb_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the 5-stage RISC-V datapath.
- Consumes EX/MEM control and data, and performs loads and stores over a valid/ready data-memory handshake.
- Stalls the front of the pipeline while an access is outstanding.
- Registers MEM_WB_Rd, MEM_WB_RegWrite and write-back data; these feed the register file and the forwarding unit.

Parameters:
- XLEN, 32, datapath and data-memory word width (byte lanes = XLEN/8; only 32 is supported).
- ADDR_W, 32, data-memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- EX_MEM_valid  in  1  EX/MEM slot holds a real instruction.
- EX_MEM_Rd  in  5  destination register.
- EX_MEM_RegWrite  in  1  instruction writes Rd.
- EX_MEM_MemRead  in  1  load.
- EX_MEM_MemWrite  in  1  store.
- EX_MEM_MemtoReg  in  1  write-back source: 1 = load data, 0 = ALU result.
- EX_MEM_funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- EX_MEM_ALU_result  in  XLEN  address, or result for non-memory instructions.
- EX_MEM_rs2_data  in  XLEN  store data.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits forced to 0).
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  memory accepts the request this cycle.
- dmem_rvalid  in  1  load response valid.
- dmem_rdata  in  XLEN  load response word.
- mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- MEM_WB_valid  out  1  registered slot valid.
- MEM_WB_Rd  out  5  registered destination.
- MEM_WB_RegWrite  out  1  registered write enable.
- MEM_WB_wdata  out  XLEN  registered write-back value.
- MEM_WB_misalign  out  1  registered misaligned-access flag.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE. All MEM_WB_* outputs = 0. dmem_req = 0. mem_stall = 0.
- Reset mid-access: state forced to IDLE, and a response arriving later is discarded.
- Access condition: access = EX_MEM_valid & (MemRead | MemWrite) & ~misalign.
- Misalignment:
  - H/HU with addr[0] = 1 is misaligned.
  - W with addr[1:0] != 0 is misaligned.
  - A misaligned load or store issues no request and forces MEM_WB_RegWrite = 0.
  - MEM_WB_misalign = 1 for that slot; latency is 1 cycle.
- FSM states:
  - IDLE: dmem_req = access.
    - Store with req & ready: complete this cycle, stay IDLE.
    - Load with req & ready: go to WAIT_RSP.
    - Access without ready: stay IDLE with req held, and addr/we/wdata/be held stable.
  - WAIT_RSP: dmem_req = 0. On dmem_rvalid, complete the load and go to IDLE.
  - dmem_rvalid is ignored in IDLE.
- Stall: mem_stall = access & ~complete, where complete is one of:
  - a store accepted in IDLE;
  - a load in WAIT_RSP with rvalid.
  - mem_stall is combinational. EX/MEM holds its value while mem_stall = 1.
- MEM/WB register update, every rising edge:
  - Stalled: load a bubble (valid = 0, RegWrite = 0, misalign = 0, wdata = 0).
  - Otherwise: capture valid, Rd and misalign. RegWrite = EX_MEM_RegWrite & EX_MEM_valid & ~misalign.
  - wdata = aligned load data if MemtoReg, else ALU_result.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Store: 1 cycle after acceptance.
  - Load: registered on the rvalid edge. Minimum is accept at cycle N, rvalid at N+1, MEM_WB valid after edge N+1.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 << addr[1:0]; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111; wdata = rs2.
  - Loads drive be = 1111.
- Load extraction: select the byte or halfword by addr[1:0] held from the request. B/H sign-extend; BU/HU zero-extend; W passes through.
- Address capture: the request's addr[1:0] and funct3 are captured on acceptance for use in WAIT_RSP.
- Undefined funct3 (011, 110, 111): treated as W.
- Bubble pass-through: EX_MEM_valid = 0 produces no request; MEM_WB_valid = 0 next cycle.

Decomposition:
- Shared package riscv_pkg:
  - funct3 size constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding MEM_IDLE, MEM_WAIT_RSP.
  - XLEN default.
- Sub-module load_store_align (combinational):
  - Inputs: funct3, addr[1:0], rs2_data, rdata.
  - Outputs: be, wdata, load_data, misalign.
- The top holds the FSM, the stall logic and the MEM/WB register.

Test Plan:
- Reset with rst = 0 while in WAIT_RSP, then rvalid = 1 -> state IDLE, all MEM_WB_* = 0, response ignored.
- ALU instruction Rd = 5, RegWrite = 1, ALU_result = 0x1234 -> next cycle MEM_WB_Rd = 5, RegWrite = 1, wdata = 0x1234, mem_stall never high.
- LB at addr 0x103, ready = 1, rvalid 2 cycles later with rdata = 0x80FFFFFF, Rd = 7 -> mem_stall high 3 cycles, then MEM_WB_wdata = 0xFFFFFF80, MEM_WB_RegWrite = 1, bubbles in MEM/WB during the stall.
- SH at addr 0x202, rs2 = 0xABCD1234, ready low 2 cycles -> req held 3 cycles with be = 1100, wdata = 0x12341234, addr = 0x200; mem_stall high 2 cycles.
- LW at addr 0x101 -> no dmem_req, MEM_WB_misalign = 1, MEM_WB_RegWrite = 0, no stall.
- LHU at addr 0x002, rdata = 0x8001FFFF -> MEM_WB_wdata = 0x00008001; back-to-back load then ALU instruction -> ALU result written the cycle after the load completes.
